prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 15 +
 rtl/prog_loader_word_packer.sv | 41 ++++
 rtl/prog_loader.sv | 154 +++++++++++++++
 tb/tb_prog_loader.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared states and constants for the program loader
package prog_loader_pkg;

    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_COLLECT,
        ST_WRITE,
        ST_REWIND,
        ST_RUN
    } state_t;

endpackage

// File: rtl/prog_loader_word_packer.sv
// rtl/prog_loader_word_packer.sv - little-endian byte-to-word assembly register
module word_packer
    import prog_loader_pkg::*;
#(
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  byte_en,
    input  logic [1:0]            byte_idx,
    input  logic [7:0]            byte_in,
    output logic [WORD_WIDTH-1:0] word,
    output logic                  word_full
);

    logic [WORD_WIDTH-1:0] word_q;
    logic [WORD_WIDTH-1:0] word_d;
    logic [WORD_WIDTH-1:0] word_asm;

    // word exposes the merge including this cycle's byte so the top can capture a complete word
    always_comb begin
        word_asm = word_q;
        if (byte_en) begin
            word_asm[{byte_idx, 3'b000} +: 8] = byte_in;
        end
        word_d = clear ? '0 : word_asm;
    end

    assign word      = word_asm;
    assign word_full = byte_en && (byte_idx == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - loads a byte stream into instruction memory, then releases the core to run
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int CNT_SIZE   = 7,
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [CNT_SIZE-1:0]   num_words,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  ld_en,
    output logic [WORD_WIDTH-1:0] Load_data,
    output logic                  rst_counter,
    output logic                  rd_en,
    output logic                  busy,
    output logic [CNT_SIZE-1:0]   words_loaded
);

    state_t                state_q, state_d;
    logic [CNT_SIZE-1:0]   count_q, count_d;
    logic [CNT_SIZE-1:0]   words_q, words_d;
    logic [CNT_SIZE-1:0]   words_inc;
    logic [1:0]            idx_q, idx_d;
    logic [WORD_WIDTH-1:0] load_data_q, load_data_d;
    logic                  ld_en_q, ld_en_d;
    logic                  rd_en_q, rd_en_d;
    logic                  rst_counter_q, rst_counter_d;
    logic                  byte_ready_q, byte_ready_d;
    logic                  busy_q, busy_d;

    logic                  accept;
    logic                  pk_clear;
    logic                  pk_full;
    logic [WORD_WIDTH-1:0] pk_word;

    assign accept    = byte_ready_q && byte_valid;
    assign words_inc = words_q + CNT_SIZE'(1);

    word_packer #(
        .WORD_WIDTH(WORD_WIDTH)
    ) u_packer (
        .clk      (clk),
        .rst      (rst),
        .clear    (pk_clear),
        .byte_en  (accept),
        .byte_idx (idx_q),
        .byte_in  (byte_data),
        .word     (pk_word),
        .word_full(pk_full)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        words_d  = words_q;
        idx_d    = idx_q;
        pk_clear = 1'b0;

        if (abort) begin
            state_d  = ST_IDLE;
            idx_d    = 2'd0;
            pk_clear = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_RUN: begin
                    if (start) begin
                        count_d  = num_words;
                        words_d  = '0;
                        idx_d    = 2'd0;
                        pk_clear = 1'b1;
                        state_d  = ST_CLR;
                    end
                end
                ST_CLR: begin
                    state_d = (count_q == '0) ? ST_REWIND : ST_COLLECT;
                end
                ST_COLLECT: begin
                    if (accept) begin
                        idx_d = idx_q + 2'd1;
                        if (pk_full) begin
                            state_d = ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    words_d  = words_inc;
                    idx_d    = 2'd0;
                    pk_clear = 1'b1;
                    state_d  = (words_inc == count_q) ? ST_REWIND : ST_COLLECT;
                end
                ST_REWIND: begin
                    state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Strobes are decoded from the next state so they leave flops aligned with the state they belong to
    always_comb begin
        ld_en_d       = (state_d == ST_WRITE);
        rd_en_d       = (state_d == ST_RUN);
        rst_counter_d = (state_d == ST_CLR) || (state_d == ST_REWIND);
        byte_ready_d  = (state_d == ST_COLLECT);
        busy_d        = (state_d == ST_CLR) || (state_d == ST_COLLECT) ||
                        (state_d == ST_WRITE) || (state_d == ST_REWIND);
        load_data_d   = load_data_q;
        if ((state_d == ST_WRITE) && (state_q == ST_COLLECT)) begin
            load_data_d = pk_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            count_q       <= '0;
            words_q       <= '0;
            idx_q         <= 2'd0;
            load_data_q   <= '0;
            ld_en_q       <= 1'b0;
            rd_en_q       <= 1'b0;
            rst_counter_q <= 1'b0;
            byte_ready_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            words_q       <= words_d;
            idx_q         <= idx_d;
            load_data_q   <= load_data_d;
            ld_en_q       <= ld_en_d;
            rd_en_q       <= rd_en_d;
            rst_counter_q <= rst_counter_d;
            byte_ready_q  <= byte_ready_d;
            busy_q        <= busy_d;
        end
    end

    assign byte_ready   = byte_ready_q;
    assign ld_en        = ld_en_q;
    assign Load_data    = load_data_q;
    assign rst_counter  = rst_counter_q;
    assign rd_en        = rd_en_q;
    assign busy         = busy_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - self-checking bench for prog_loader
module tb_prog_loader;

    localparam int CNT_SIZE   = 7;
    localparam int WORD_WIDTH = 32;

    logic                  clk;
    logic                  rst;
    logic                  start;
    logic                  abort;
    logic [CNT_SIZE-1:0]   num_words;
    logic                  byte_valid;
    logic [7:0]            byte_data;
    logic                  byte_ready;
    logic                  ld_en;
    logic [WORD_WIDTH-1:0] Load_data;
    logic                  rst_counter;
    logic                  rd_en;
    logic                  busy;
    logic [CNT_SIZE-1:0]   words_loaded;

    prog_loader #(
        .CNT_SIZE  (CNT_SIZE),
        .WORD_WIDTH(WORD_WIDTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .num_words   (num_words),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_ready  (byte_ready),
        .ld_en       (ld_en),
        .Load_data   (Load_data),
        .rst_counter (rst_counter),
        .rd_en       (rd_en),
        .busy        (busy),
        .words_loaded(words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          nw;
        int          gap;
        logic [7:0]  b[16];
        logic [31:0] w[4];
    } vec_t;

    vec_t        vec[5];
    logic [7:0]  cur_b[16];
    logic [31:0] sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          ld_cnt = 0;
    int          rc_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Entered and left at posedge+1
    task automatic do_start(input int nw);
        start     = 1'b1;
        num_words = CNT_SIZE'(nw);
        @(posedge clk);
        #1;
        start     = 1'b0;
        num_words = 7'h55;
    endtask

    task automatic feed(input int n, input int gap);
        for (int k = 0; k < n; k++) begin
            int   t;
            logic acc;
            byte_valid = 1'b1;
            byte_data  = cur_b[k];
            acc = 1'b0;
            t   = 0;
            while (!acc && t < 100) begin
                @(negedge clk);
                acc = byte_ready;
                @(posedge clk);
                t++;
            end
            #1;
            byte_valid = 1'b0;
            byte_data  = 8'h00;
            if (!acc) chk("byte_accept_timeout", 32'(acc), 32'd1);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_run(output int cyc);
        cyc = 0;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (rd_en) break;
        end
        chk("run_reached", 32'(rd_en), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc;
        int ld_base;
        int rc_base;

        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        num_words  = '0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;

        fork
            forever begin
                @(negedge clk);
                if (!rst) begin
                    if (ld_en) begin
                        ld_cnt++;
                        if (sb.size() == 0) chk("unexpected_ld_en", 32'(ld_en), 32'd0);
                        else chk("ld_data", Load_data, sb.pop_front());
                    end
                    if (rst_counter) rc_cnt++;
                    chk("strobe_excl", 32'((int'(ld_en) + int'(rd_en) + int'(rst_counter)) > 1), 32'd0);
                end
            end
        join_none

        vec[0].nw = 2; vec[0].gap = 0;
        vec[0].b = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h10, 8'h00,
                     8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vec[0].w = '{32'h0000_0013, 32'h0010_00B3, 32'h0, 32'h0};
        vec[1] = vec[0];
        vec[1].gap = 3;
        vec[2].nw = 0; vec[2].gap = 0;
        vec[2].b = '{default: 8'h00};
        vec[2].w = '{default: 32'h0};
        vec[3].nw = 1; vec[3].gap = 1;
        vec[3].b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00, 8'h00, 8'h00, 8'h00,
                     8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vec[3].w = '{32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0};
        vec[4].nw = 3; vec[4].gap = 0;
        vec[4].b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hAA, 8'h55, 8'hFF, 8'h00,
                     8'h80, 8'h7F, 8'h01, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h00};
        vec[4].w = '{32'h0403_0201, 32'h00FF_55AA, 32'hFE01_7F80, 32'h0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_strobes", 32'({ld_en, rd_en, rst_counter, byte_ready, busy}), 32'd0);
        chk("reset_load_data", Load_data, 32'd0);
        chk("reset_words", 32'(words_loaded), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        byte_valid = 1'b1;
        byte_data  = 8'h99;
        repeat (3) begin
            @(negedge clk);
            chk("idle_byte_ready", 32'(byte_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        byte_data  = 8'h00;

        for (int i = 0; i < 5; i++) begin
            cur_b = vec[i].b;
            for (int j = 0; j < vec[i].nw; j++) sb.push_back(vec[i].w[j]);
            ld_base = ld_cnt;
            rc_base = rc_cnt;
            do_start(vec[i].nw);
            feed(4 * vec[i].nw, vec[i].gap);
            wait_run(cyc);
            chk($sformatf("v%0d_words_loaded", i), 32'(words_loaded), 32'(vec[i].nw));
            chk($sformatf("v%0d_ld_count", i), 32'(ld_cnt - ld_base), 32'(vec[i].nw));
            chk($sformatf("v%0d_rst_counter_pulses", i), 32'(rc_cnt - rc_base), 32'd2);
            chk($sformatf("v%0d_busy_in_run", i), 32'(busy), 32'd0);
            chk($sformatf("v%0d_run_rd_en_held", i), 32'(rd_en), 32'd1);
            chk($sformatf("v%0d_sb_drained", i), 32'(sb.size()), 32'd0);
            if (vec[i].nw == 0) chk("zero_len_latency", 32'(cyc), 32'd3);
        end

        // restart from RUN
        start     = 1'b1;
        num_words = 7'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("restart_rd_en", 32'(rd_en), 32'd0);
        chk("restart_rst_counter", 32'(rst_counter), 32'd1);
        chk("restart_words", 32'(words_loaded), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        cur_b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h00, 8'h00, 8'h00, 8'h00,
                  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        sb.push_back(32'hD4C3_B2A1);
        ld_base = ld_cnt;
        feed(4, 0);
        wait_run(cyc);
        chk("restart_words_final", 32'(words_loaded), 32'd1);
        chk("restart_ld_count", 32'(ld_cnt - ld_base), 32'd1);

        // abort and start together in RUN
        abort     = 1'b1;
        start     = 1'b1;
        num_words = 7'd3;
        @(posedge clk);
        #1;
        abort = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("abort_wins_busy", 32'(busy), 32'd0);
        chk("abort_wins_rd_en", 32'(rd_en), 32'd0);
        chk("abort_wins_rst_counter", 32'(rst_counter), 32'd0);
        chk("idle_words_held", 32'(words_loaded), 32'd1);
        @(posedge clk);
        #1;

        // abort after two bytes of the first word
        cur_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00,
                  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        ld_base = ld_cnt;
        do_start(2);
        feed(2, 0);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_byte_ready", 32'(byte_ready), 32'd0);
        chk("abort_rd_en", 32'(rd_en), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("abort_no_ld", 32'(ld_cnt - ld_base), 32'd0);

        cur_b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00,
                  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        sb.push_back(32'h0403_0201);
        ld_base = ld_cnt;
        do_start(1);
        feed(4, 0);
        wait_run(cyc);
        chk("post_abort_ld_count", 32'(ld_cnt - ld_base), 32'd1);
        chk("post_abort_sb_drained", 32'(sb.size()), 32'd0);

        // reset asserted during the WRITE cycle
        cur_b = '{8'h5A, 8'h6B, 8'h7C, 8'h8D, 8'h00, 8'h00, 8'h00, 8'h00,
                  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        do_start(1);
        feed(4, 0);
        chk("write_cycle_ld_en", 32'(ld_en), 32'd1);
        rst = 1'b1;
        #1;
        chk("midwrite_rst_strobes", 32'({ld_en, rd_en, rst_counter, byte_ready, busy}), 32'd0);
        chk("midwrite_rst_load_data", Load_data, 32'd0);
        chk("midwrite_rst_words", 32'(words_loaded), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ld_base = ld_cnt;
        rc_base = rc_cnt;
        byte_valid = 1'b1;
        byte_data  = 8'hC0;
        repeat (10) @(posedge clk);
        #1;
        byte_valid = 1'b0;
        chk("post_rst_no_ld", 32'(ld_cnt - ld_base), 32'd0);
        chk("post_rst_no_rst_counter", 32'(rc_cnt - rc_base), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
